// File: rtl/load_store_unit.sv
// Core-side load/store initiator: one outstanding word-aligned access with byte enables.
// Accepted request strobes memory next cycle; ack -> rsp pulse one cycle later; faults respond next cycle.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_ILL = 2'b10;
  localparam logic [1:0] F_TMO = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ld_q, ld_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              req_ready_q, req_ready_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_fault_q, rsp_fault_d;

  logic        illegal, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request classification on the raw inputs, used only in IDLE
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_load == is_store) begin
      illegal = 1'b1;
    end else if (is_store) begin
      illegal = funct3[2] || (funct3 == 3'b011);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    if (funct3[1:0] == 2'b01) begin
      misaligned = addr[0];
    end else if (funct3[1:0] == 2'b10) begin
      misaligned = (addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << addr[1:0];
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of the returned word
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_d        = ld_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    req_ready_d = req_ready_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 32'd0;
    rsp_fault_d = F_OK;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ld_d        = is_load;
          funct3_d    = funct3;
          off_d       = addr[1:0];
          req_ready_d = 1'b0;
          if (illegal || misaligned) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = illegal ? F_ILL : F_MIS;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = '0;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = is_load ? 4'b1111 : st_be;
            mem_wdata_d = is_load ? 32'd0 : st_data;
            mem_read_d  = is_load;
            mem_write_d = is_store;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack is checked first so it wins over a coincident timeout
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = mem_ack ? F_OK : F_TMO;
          rsp_data_d  = (mem_ack && ld_q) ? ld_data : 32'd0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'd0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ld_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      req_ready_q <= 1'b1;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_fault_q <= F_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      req_ready_q <= req_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_addr, mem_wdata, mem_rdata, rsp_data;
  logic [3:0]  mem_be;
  logic        mem_read, mem_write, mem_ack, rsp_valid;
  logic [1:0]  rsp_fault;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns in the cycle after acceptance
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    tick();
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, mem_read, mem_write, rsp_valid, mem_be, rsp_fault} !== 10'b10_0000_0000 ||
        mem_addr !== 32'd0 || rsp_data !== 32'd0)
      $display("FAIL reset_state ready=%b rd=%b wr=%b rv=%b be=%b flt=%b addr=%h data=%h (want ready=1, rest 0)",
               req_ready, mem_read, mem_write, rsp_valid, mem_be, rsp_fault, mem_addr, rsp_data);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_word();
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF);
    mem_ack = 1'b1;
    total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h8 || mem_be !== 4'b1111 ||
        mem_wdata !== 32'hDEAD_BEEF || req_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL sw_request wr=%b rd=%b addr=%h be=%b wd=%h ready=%b rv=%b want wr=1 rd=0 addr=8 be=1111 wd=deadbeef ready=0 rv=0",
               mem_write, mem_read, mem_addr, mem_be, mem_wdata, req_ready, rsp_valid);
    else passed++;
    tick();
    mem_ack = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 2'b00 || rsp_data !== 32'd0 || mem_write !== 1'b0)
      $display("FAIL sw_response rv=%b flt=%b data=%h wr=%b want rv=1 flt=00 data=0 wr=0",
               rsp_valid, rsp_fault, rsp_data, mem_write);
    else passed++;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL sw_return rv=%b ready=%b want rv=0 ready=1", rsp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_store_narrow();
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
    total++;
    if (mem_addr !== 32'h10 || mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5_A5A5 || mem_write !== 1'b1)
      $display("FAIL sb_request addr=%h be=%b wd=%h wr=%b want addr=10 be=1000 wd=a5a5a5a5 wr=1",
               mem_addr, mem_be, mem_wdata, mem_write);
    else passed++;
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF);
    total++;
    if (mem_addr !== 32'h20 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF)
      $display("FAIL sh_request addr=%h be=%b wd=%h want addr=20 be=1100 wd=beefbeef",
               mem_addr, mem_be, mem_wdata);
    else passed++;
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6];
    logic [31:0] a   [6];
    logic [31:0] rd  [6];
    logic [31:0] exp [6];
    f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
    a   = '{32'h6, 32'h6, 32'h6, 32'h4, 32'h4, 32'h4};
    rd  = '{32'h12F4_5678, 32'h12F4_5678, 32'h12F4_5678, 32'h12F4_8001, 32'h12F4_8001, 32'h12F4_8001};
    exp = '{32'hFFFF_FFF4, 32'h0000_00F4, 32'h0000_12F4, 32'h0000_8001, 32'hFFFF_8001, 32'h12F4_8001};
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, f3[i], a[i], 32'hFFFF_FFFF);
      total++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_be !== 4'b1111 || mem_addr !== {a[i][31:2], 2'b00})
        $display("FAIL load_request[%0d] rd=%b wr=%b be=%b addr=%h want rd=1 wr=0 be=1111 addr=%h",
                 i, mem_read, mem_write, mem_be, mem_addr, {a[i][31:2], 2'b00});
      else passed++;
      mem_rdata = rd[i]; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'd0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_fault !== 2'b00)
        $display("FAIL load_data[%0d] rv=%b data=%h flt=%b want rv=1 data=%h flt=00",
                 i, rsp_valid, rsp_data, rsp_fault, exp[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_faults();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'd0);
    total++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 2'b01 || mem_read !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 1'b0)
      $display("FAIL misaligned rv=%b flt=%b rd=%b data=%h ready=%b want rv=1 flt=01 rd=0 data=0 ready=0",
               rsp_valid, rsp_fault, mem_read, rsp_data, req_ready);
    else passed++;
    tick();
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0001, 32'd0);
    total++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 2'b10 || mem_read !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL illegal_both rv=%b flt=%b rd=%b wr=%b want rv=1 flt=10 rd=0 wr=0",
               rsp_valid, rsp_fault, mem_read, mem_write);
    else passed++;
    tick();
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'd0);
    total++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 2'b10 || mem_write !== 1'b0)
      $display("FAIL illegal_store rv=%b flt=%b wr=%b want rv=1 flt=10 wr=0", rsp_valid, rsp_fault, mem_write);
    else passed++;
    tick();
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0003, 32'd0);
    total++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 2'b01)
      $display("FAIL misaligned_lhu rv=%b flt=%b want rv=1 flt=01", rsp_valid, rsp_fault);
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    int waits;
    waits = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (mem_read === 1'b1 && rsp_valid === 1'b0) waits++;
      tick();
    end
    total++;
    if (waits !== 16 || rsp_valid !== 1'b1 || rsp_fault !== 2'b11 || rsp_data !== 32'd0 || mem_read !== 1'b0)
      $display("FAIL timeout waits=%0d rv=%b flt=%b data=%h rd=%b want waits=16 rv=1 flt=11 data=0 rd=0",
               waits, rsp_valid, rsp_fault, rsp_data, mem_read);
    else passed++;
    tick();
    waits = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (mem_read === 1'b1 && rsp_valid === 1'b0) waits++;
      if (i == 15) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 32'd0;
    total++;
    if (waits !== 16 || rsp_valid !== 1'b1 || rsp_fault !== 2'b00 || rsp_data !== 32'hCAFE_F00D)
      $display("FAIL ack_at_limit waits=%0d rv=%b flt=%b data=%h want waits=16 rv=1 flt=00 data=cafef00d",
               waits, rsp_valid, rsp_fault, rsp_data);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    pulses = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || mem_be !== 4'd0)
      $display("FAIL reset_mid_wait ready=%b rd=%b wr=%b be=%b want ready=1 rd=0 wr=0 be=0000",
               req_ready, mem_read, mem_write, mem_be);
    else passed++;
    tick();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b0) pulses++;
      tick();
    end
    total++;
    if (pulses !== 0 || req_ready !== 1'b1)
      $display("FAIL stray_ack rsp_pulses=%0d ready=%b want 0 pulses ready=1", pulses, req_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int accepted;
    accepted = 0;
    // Request held continuously: second op must be taken as soon as the LSU returns to idle
    req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'h1;
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_write === 1'b1) accepted++;
    end
    req_valid = 1'b0; is_store = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    total++;
    if (accepted !== 2)
      $display("FAIL back_to_back write_cycles=%0d want 2", accepted);
    else passed++;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    test_reset();
    test_store_word();
    test_store_narrow();
    test_loads();
    test_faults();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the byte-lane data memory.
- Accepts one load or store per handshake from the execute stage and drives a word-aligned request with byte enables to data memory.
- Holds the request until memory acknowledges, then returns formatted load data or a fault code to writeback.
- Single outstanding transaction; the pipeline stalls on req_ready=0.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before a timeout fault is raised.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  core presents a memory operation.
- req_ready  out  1  LSU is idle and can accept a request.
- is_load  in  1  operation is a load.
- is_store  in  1  operation is a store.
- funct3  in  3  RISC-V width/sign field.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-aligned store data.
- mem_be  out  4  byte enables.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  32  raw word from memory.
- mem_ack  in  1  memory completed the access.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  formatted load data; 0 for stores and faults.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 illegal, 11 timeout.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0. All outputs 0 except req_ready=1. Any in-flight transaction is discarded, and mem_ack in IDLE is ignored.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch is_load, is_store, funct3, addr, and wdata.
  - Classify the request:
    - illegal: is_load==is_store; store with funct3[2]=1 or funct3=011; load with funct3 in {011,110,111}.
    - misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Fault -> RESP with the code latched, and no memory strobe ever asserted. Illegal takes priority over misaligned.
  - Otherwise -> WAIT.
- WAIT:
  - Signal levels: req_ready=0; mem_read=is_load; mem_write=is_store; mem_addr, mem_be, and mem_wdata held stable.
  - Counter increments each cycle, starting at 0 on entry.
  - mem_ack=1 -> RESP with fault 00. Capture mem_rdata that cycle and drop strobes on the next cycle.
  - Else if counter==TIMEOUT_CYCLES-1 -> RESP with fault 11.
  - If mem_ack and the timeout fall in the same cycle, ack wins.
- RESP:
  - rsp_valid=1 for exactly one cycle, req_ready=0, then -> IDLE.
  - req_valid during WAIT or RESP is ignored; the core must hold it.
- Store formatting, with off=addr[1:0]:
  - SB (000): be=0001<<off, byte replicated in all 4 lanes.
  - SH (001): be=0011<<off, halfword replicated in both halves.
  - SW (010): be=1111, data unchanged.
- Load formatting: mem_be=1111 on loads. Select the lane by off.
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend halfword (off[1] selects half).
  - LHU: zero-extend halfword.
  - LW: full word.
- Latency: request accepted at edge N, strobes asserted from cycle N+1. Zero-wait ack in N+1 gives rsp_valid in N+2. Faults give rsp_valid at N+1.

Test Plan:
- SW addr=0x0000_0008 wdata=0xDEADBEEF, ack on first WAIT cycle -> mem_addr=0x08, mem_be=1111, mem_wdata=0xDEADBEEF, mem_write one cycle. rsp_valid two cycles after acceptance, rsp_fault=00.
- SB addr=0x0000_0013 wdata=0x0000_00A5 -> mem_addr=0x10, mem_be=1000, mem_wdata=0xA5A5A5A5.
- LB/LBU addr=0x0000_0006, mem_rdata=0x12F4_5678 -> LB rsp_data=0xFFFF_FFF4, LBU rsp_data=0x0000_00F4. LH at 0x06 -> 0x0000_12F4.
- LW addr=0x0000_0002 -> rsp_fault=01 one cycle after acceptance, mem_read never asserted. is_load=is_store=1 -> rsp_fault=10.
- LW with mem_ack held 0 -> exactly 16 WAIT cycles, then rsp_fault=11, rsp_data=0. Repeat with ack on the 16th cycle -> fault 00.
- Assert rst mid-WAIT, then pulse mem_ack -> no rsp_valid. req_ready=1 immediately and all strobes 0.
